// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between an instruction-fetch requester
// (if_*) and a load/store requester (ls_*). Arbitration happens only while
// the port is idle. Load/store normally has priority. Stores finish in the
// grant cycle. Reads (a fetch, or a load) hold the port for LAT more cycles
// until the read data returns.
//
// Optional feature, selected by the macro ARB_STARVE_GUARD_EN:
//   When defined, a 4-bit starvation counter tracks how many idle cycles in
//   a row the fetch port lost to load/store. Once the counter reaches
//   STARVE_MAX, the next arbitration goes to fetch. When undefined, there
//   is no counter and load/store has strict priority.
//
// Parameters:
//   ADDR        address width
//   W_OPR       data width
//   LAT         memory read latency in cycles (1..7)
//   STARVE_MAX  fetch losses that trigger forced fetch grant (1..15)
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   if_req_i/if_addr_i          fetch request and address
//   if_gnt_o                    fetch accepted this cycle
//   if_rvalid_o/if_rdata_o      fetch read return; rdata holds last value
//   ls_req_i/ls_write_i         load/store request, 1 = store
//   ls_addr_i/ls_wdata_i        load/store address and store data
//   ls_gnt_o                    load/store accepted this cycle
//   ls_rvalid_o/ls_rdata_o      load return; rdata holds last value
//   stall_o                     load/store waiting (request high, no grant)
//   mem_en_o/mem_we_o           memory strobe and write enable
//   mem_addr_o/mem_wdata_o      memory address and write data
//   mem_rdata_i                 memory read data, valid LAT cycles after a read
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR       = 16,
    parameter int W_OPR      = 32,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             if_req_i,
    input  logic [ADDR-1:0]  if_addr_i,
    output logic             if_gnt_o,
    output logic             if_rvalid_o,
    output logic [W_OPR-1:0] if_rdata_o,

    input  logic             ls_req_i,
    input  logic             ls_write_i,
    input  logic [ADDR-1:0]  ls_addr_i,
    input  logic [W_OPR-1:0] ls_wdata_i,
    output logic             ls_gnt_o,
    output logic             ls_rvalid_o,
    output logic [W_OPR-1:0] ls_rdata_o,

    output logic             stall_o,

    output logic             mem_en_o,
    output logic             mem_we_o,
    output logic [ADDR-1:0]  mem_addr_o,
    output logic [W_OPR-1:0] mem_wdata_o,
    input  logic [W_OPR-1:0] mem_rdata_i
);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    logic [2:0]       lat_q, lat_d;
    logic [W_OPR-1:0] if_rdata_q, ls_rdata_q;
    logic             force_if;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    assign force_if = (starve_q >= 4'(STARVE_MAX));

    // Counts idle cycles where fetch wanted the port but load/store got it.
    // ls_gnt_o can only be high in IDLE, so no separate state test is needed.
    always_comb begin
        starve_d = starve_q;
        if (!if_req_i || if_gnt_o) begin
            starve_d = '0;
        end else if (ls_gnt_o && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Constant 0 for every legal STARVE_MAX: load/store has strict priority.
    assign force_if = (STARVE_MAX < 1);
`endif

    // NOTE: every output and next-state signal gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lat_d       = lat_q;
        if_gnt_o    = 1'b0;
        ls_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        ls_rvalid_o = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        // Reset blanks every combinational output in the cycle it is seen.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (ls_req_i && !(if_req_i && force_if)) begin
                        ls_gnt_o    = 1'b1;
                        mem_en_o    = 1'b1;
                        mem_we_o    = ls_write_i;
                        mem_addr_o  = ls_addr_i;
                        mem_wdata_o = ls_wdata_i;
                        // Stores complete in the grant cycle; only loads wait.
                        if (!ls_write_i) begin
                            state_d = WAIT;
                            owner_d = OWN_LS;
                            lat_d   = 3'(LAT);
                        end
                    end else if (if_req_i) begin
                        if_gnt_o   = 1'b1;
                        mem_en_o   = 1'b1;
                        mem_addr_o = if_addr_i;
                        state_d    = WAIT;
                        owner_d    = OWN_IF;
                        lat_d      = 3'(LAT);
                    end
                end

                WAIT: begin
                    lat_d = lat_q - 3'd1;
                    // The counter reaches 0 on this edge: the data is on
                    // mem_rdata_i now, LAT cycles after the grant.
                    if (lat_q == 3'd1) begin
                        if_rvalid_o = (owner_q == OWN_IF);
                        ls_rvalid_o = (owner_q == OWN_LS);
                        state_d     = IDLE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            lat_q      <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            lat_q   <= lat_d;
            if (if_rvalid_o) begin
                if_rdata_q <= mem_rdata_i;
            end
            if (ls_rvalid_o) begin
                ls_rdata_q <= mem_rdata_i;
            end
        end
    end

    // Return data passes straight through in the rvalid cycle and is held
    // afterwards; reset forces it to 0 in the same cycle.
    assign if_rdata_o = reset ? '0 : (if_rvalid_o ? mem_rdata_i : if_rdata_q);
    assign ls_rdata_o = reset ? '0 : (ls_rvalid_o ? mem_rdata_i : ls_rdata_q);

    assign stall_o = ls_req_i && !ls_gnt_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter with default parameters
// (ADDR=16, W_OPR=32, LAT=2, STARVE_MAX=4). It has two phases:
//   1. A directed vector table with hand-derived expectations. It covers
//      the fetch read, both requesters at once, back-to-back stores,
//      starvation with and without ARB_STARVE_GUARD_EN, and reset during
//      a read.
//   2. Random stimulus compared against a reference model. The model
//      tracks an outstanding read as an absolute return cycle number.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int LAT        = 2;
    localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic        ifr;
        logic [15:0] ifa;
        logic        lsr;
        logic        lsw;
        logic [15:0] lsa;
        logic [31:0] lsd;
        logic [31:0] mrd;
    } in_t;

    typedef struct packed {
        logic        ifg;
        logic        lsg;
        logic        ifv;
        logic        lsv;
        logic        stall;
        logic        en;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] ifd;
        logic [31:0] lsd;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_i;
    logic [15:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_i;
    logic        ls_write_i;
    logic [15:0] ls_addr_i;
    logic [31:0] ls_wdata_i;
    logic        ls_gnt_o;
    logic        ls_rvalid_o;
    logic [31:0] ls_rdata_o;
    logic        stall_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_gnt_o   (if_gnt_o),
        .if_rvalid_o(if_rvalid_o),
        .if_rdata_o (if_rdata_o),
        .ls_req_i   (ls_req_i),
        .ls_write_i (ls_write_i),
        .ls_addr_i  (ls_addr_i),
        .ls_wdata_i (ls_wdata_i),
        .ls_gnt_o   (ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o),
        .ls_rdata_o (ls_rdata_o),
        .stall_o    (stall_o),
        .mem_en_o   (mem_en_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic in_t mk_in(logic rst, logic ifr, logic [15:0] ifa, logic lsr,
                                  logic lsw, logic [15:0] lsa, logic [31:0] lsd,
                                  logic [31:0] mrd);
        in_t x;
        x.rst = rst; x.ifr = ifr; x.ifa = ifa; x.lsr = lsr;
        x.lsw = lsw; x.lsa = lsa; x.lsd = lsd; x.mrd = mrd;
        return x;
    endfunction

    function automatic exp_t mk_exp(logic ifg, logic lsg, logic ifv, logic lsv,
                                    logic stall, logic en, logic we, logic [15:0] addr,
                                    logic [31:0] wdata, logic [31:0] ifd, logic [31:0] lsd);
        exp_t e;
        e.ifg = ifg; e.lsg = lsg; e.ifv = ifv; e.lsv = lsv; e.stall = stall;
        e.en = en; e.we = we; e.addr = addr; e.wdata = wdata; e.ifd = ifd; e.lsd = lsd;
        return e;
    endfunction

    task automatic apply(input in_t x);
        reset       = x.rst;
        if_req_i    = x.ifr;
        if_addr_i   = x.ifa;
        ls_req_i    = x.lsr;
        ls_write_i  = x.lsw;
        ls_addr_i   = x.lsa;
        ls_wdata_i  = x.lsd;
        mem_rdata_i = x.mrd;
    endtask

    task automatic compare(input exp_t e, input string tag);
        check({tag, " if_gnt"},    64'(if_gnt_o),    64'(e.ifg));
        check({tag, " ls_gnt"},    64'(ls_gnt_o),    64'(e.lsg));
        check({tag, " if_rvalid"}, 64'(if_rvalid_o), 64'(e.ifv));
        check({tag, " ls_rvalid"}, 64'(ls_rvalid_o), 64'(e.lsv));
        check({tag, " stall"},     64'(stall_o),     64'(e.stall));
        check({tag, " mem_en"},    64'(mem_en_o),    64'(e.en));
        check({tag, " mem_we"},    64'(mem_we_o),    64'(e.we));
        if (e.en) check({tag, " mem_addr"}, 64'(mem_addr_o), 64'(e.addr));
        if (e.en && e.we) check({tag, " mem_wdata"}, 64'(mem_wdata_o), 64'(e.wdata));
        check({tag, " if_rdata"},  64'(if_rdata_o),  64'(e.ifd));
        check({tag, " ls_rdata"},  64'(ls_rdata_o),  64'(e.lsd));
    endtask

    // Reference model: an outstanding read is remembered as the absolute
    // cycle on which its data returns; the port is busy until then.
    int          m_cyc    = 0;
    int          m_ret    = -1;
    bit          m_own_ls = 1'b0;
    int          m_starve = 0;
    logic [31:0] m_if_last = '0;
    logic [31:0] m_ls_last = '0;

    task automatic model_step(input in_t x, output exp_t e);
        bit ls_w;
        bit if_w;
        bit frc;
        e = '0;
        if (x.rst) begin
            e.stall   = x.lsr;
            m_ret     = -1;
            m_starve  = 0;
            m_if_last = '0;
            m_ls_last = '0;
        end else if (m_ret >= 0) begin
            if (m_cyc == m_ret) begin
                if (m_own_ls) begin e.lsv = 1'b1; m_ls_last = x.mrd; end
                else          begin e.ifv = 1'b1; m_if_last = x.mrd; end
                m_ret = -1;
            end
            e.stall = x.lsr;
            if (!x.ifr) m_starve = 0;
        end else begin
            frc  = GUARD && (m_starve >= STARVE_MAX);
            ls_w = x.lsr && !(x.ifr && frc);
            if_w = x.ifr && !ls_w;
            if (ls_w) begin
                e.lsg = 1'b1; e.en = 1'b1; e.we = x.lsw; e.addr = x.lsa; e.wdata = x.lsd;
                if (!x.lsw) begin m_ret = m_cyc + LAT; m_own_ls = 1'b1; end
            end
            if (if_w) begin
                e.ifg = 1'b1; e.en = 1'b1; e.addr = x.ifa;
                m_ret = m_cyc + LAT; m_own_ls = 1'b0;
            end
            e.stall = x.lsr && !ls_w;
            if (!x.ifr || if_w) m_starve = 0;
            else if (ls_w)      m_starve = (m_starve < 15) ? m_starve + 1 : 15;
        end
        e.ifd = m_if_last;
        e.lsd = m_ls_last;
        m_cyc++;
    endtask

    initial begin
        vec_t        tbl[$];
        vec_t        v;
        logic [31:0] ifd_hold;
        in_t         x;
        exp_t        e;

        apply(mk_in(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0));

        // Reset with a fetch request pending: reset wins, everything 0.
        v.i = mk_in(1, 1, 16'h0010, 0, 0, 16'h0, 0, 0);
        v.e = mk_exp(0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0); tbl.push_back(v);
        // Fetch read, addr 0x0010, data 0xDEADBEEF returns on cycle 2.
        v.i = mk_in(0, 1, 16'h0010, 0, 0, 16'h0, 0, 0);
        v.e = mk_exp(1, 0, 0, 0, 0, 1, 0, 16'h0010, 0, 0, 0); tbl.push_back(v);
        v.i = mk_in(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        v.e = mk_exp(0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0); tbl.push_back(v);
        v.i = mk_in(0, 0, 16'h0, 0, 0, 16'h0, 0, 32'hDEADBEEF);
        v.e = mk_exp(0, 0, 1, 0, 0, 0, 0, 16'h0, 0, 32'hDEADBEEF, 0); tbl.push_back(v);
        // Next grant on cycle 3; rdata holds meanwhile.
        v.i = mk_in(0, 1, 16'h0020, 0, 0, 16'h0, 0, 0);
        v.e = mk_exp(1, 0, 0, 0, 0, 1, 0, 16'h0020, 0, 32'hDEADBEEF, 0); tbl.push_back(v);
        v.i = mk_in(0, 0, 16'h0, 0, 0, 16'h0, 0, 32'h1);
        v.e = mk_exp(0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 32'hDEADBEEF, 0); tbl.push_back(v);
        v.i = mk_in(0, 0, 16'h0, 0, 0, 16'h0, 0, 32'h11111111);
        v.e = mk_exp(0, 0, 1, 0, 0, 0, 0, 16'h0, 0, 32'h11111111, 0); tbl.push_back(v);
        // Both request, ls load wins; fetch granted the cycle after ls_rvalid.
        v.i = mk_in(0, 1, 16'h0030, 1, 0, 16'h0040, 0, 0);
        v.e = mk_exp(0, 1, 0, 0, 0, 1, 0, 16'h0040, 0, 32'h11111111, 0); tbl.push_back(v);
        v.i = mk_in(0, 1, 16'h0030, 0, 0, 16'h0, 0, 0);
        v.e = mk_exp(0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 32'h11111111, 0); tbl.push_back(v);
        v.i = mk_in(0, 1, 16'h0030, 0, 0, 16'h0, 0, 32'hCAFEF00D);
        v.e = mk_exp(0, 0, 0, 1, 0, 0, 0, 16'h0, 0, 32'h11111111, 32'hCAFEF00D); tbl.push_back(v);
        v.i = mk_in(0, 1, 16'h0030, 0, 0, 16'h0, 0, 0);
        v.e = mk_exp(1, 0, 0, 0, 0, 1, 0, 16'h0030, 0, 32'h11111111, 32'hCAFEF00D); tbl.push_back(v);
        v.i = mk_in(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        v.e = mk_exp(0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 32'h11111111, 32'hCAFEF00D); tbl.push_back(v);
        v.i = mk_in(0, 0, 16'h0, 0, 0, 16'h0, 0, 32'h12345678);
        v.e = mk_exp(0, 0, 1, 0, 0, 0, 0, 16'h0, 0, 32'h12345678, 32'hCAFEF00D); tbl.push_back(v);
        // Four back-to-back stores, 0x0100..0x0103.
        for (int k = 0; k < 4; k++) begin
            v.i = mk_in(0, 0, 16'h0, 1, 1, 16'h0100 + 16'(k), 32'hA0 + 32'(k), 0);
            v.e = mk_exp(0, 1, 0, 0, 0, 1, 1, 16'h0100 + 16'(k), 32'hA0 + 32'(k),
                         32'h12345678, 32'hCAFEF00D);
            tbl.push_back(v);
        end
        // Stores every cycle plus a constant fetch request.
        for (int k = 0; k < 7; k++) begin
            v.i = mk_in(0, 1, 16'h0200, 1, 1, 16'h0300 + 16'(k), 32'(k), 32'hBEEF0000 + 32'(k));
            v.e = mk_exp(0, 1, 0, 0, 0, 1, 1, 16'h0300 + 16'(k), 32'(k),
                         32'h12345678, 32'hCAFEF00D);
`ifdef ARB_STARVE_GUARD_EN
            if (k == 4) v.e = mk_exp(1, 0, 0, 0, 1, 1, 0, 16'h0200, 0, 32'h12345678, 32'hCAFEF00D);
            if (k == 5) v.e = mk_exp(0, 0, 0, 0, 1, 0, 0, 16'h0, 0, 32'h12345678, 32'hCAFEF00D);
            if (k == 6) v.e = mk_exp(0, 0, 1, 0, 1, 0, 0, 16'h0, 0, 32'hBEEF0006, 32'hCAFEF00D);
`endif
            tbl.push_back(v);
        end
        ifd_hold = GUARD ? 32'hBEEF0006 : 32'h12345678;
        v.i = mk_in(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        v.e = mk_exp(0, 0, 0, 0, 0, 0, 0, 16'h0, 0, ifd_hold, 32'hCAFEF00D); tbl.push_back(v);
        // Reset during WAIT cycle 1 aborts the read; grant right after reset.
        v.i = mk_in(0, 1, 16'h0050, 0, 0, 16'h0, 0, 0);
        v.e = mk_exp(1, 0, 0, 0, 0, 1, 0, 16'h0050, 0, ifd_hold, 32'hCAFEF00D); tbl.push_back(v);
        v.i = mk_in(1, 1, 16'h0050, 0, 0, 16'h0, 0, 32'h55555555);
        v.e = mk_exp(0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0); tbl.push_back(v);
        v.i = mk_in(0, 1, 16'h0060, 0, 0, 16'h0, 0, 32'h55555555);
        v.e = mk_exp(1, 0, 0, 0, 0, 1, 0, 16'h0060, 0, 0, 0); tbl.push_back(v);
        v.i = mk_in(0, 0, 16'h0, 0, 0, 16'h0, 0, 0);
        v.e = mk_exp(0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 0); tbl.push_back(v);
        v.i = mk_in(0, 0, 16'h0, 0, 0, 16'h0, 0, 32'h66666666);
        v.e = mk_exp(0, 0, 1, 0, 0, 0, 0, 16'h0, 0, 32'h66666666, 0); tbl.push_back(v);

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k].i);
            @(negedge clk);
            compare(tbl[k].e, $sformatf("vec%0d", k));
            @(posedge clk);
            #1;
        end

        // Random phase against the reference model; first cycle is a reset.
        for (int c = 0; c < 3000; c++) begin
            x.rst = (c == 0) || ($urandom_range(0, 63) == 0);
            x.ifr = ($urandom_range(0, 3) != 0);
            x.ifa = 16'($urandom);
            x.lsr = ($urandom_range(0, 3) != 0);
            x.lsw = 1'($urandom);
            x.lsa = 16'($urandom);
            x.lsd = $urandom;
            x.mrd = $urandom;
            apply(x);
            model_step(x, e);
            @(negedge clk);
            compare(e, $sformatf("rnd%0d", c));
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
